booth_seq_ctrl: RTL and testbench

Sequential controller for the radix-4 Booth partial-product generator, which takes a 3-bit Booth code, a 2-bit digit position and an 8-bit signed multiplicand, and returns a registered 16-bit partial product. It accepts one signed 8×8 multiply request, issues the four Booth digits of the multiplier one per cycle to a single generator instance, and accumulates the returned partial products into a 16-bit signed product. It sits between the requesting datapath and the partial-product generator, so one generator serves a full multiply.

---
 rtl/booth_pkg.sv | 38 +++
 rtl/booth_digit_sel.sv | 40 ++++
 rtl/booth_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_pkg : shared types, widths and Booth-digit helpers for booth_seq_ctrl |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package booth_pkg;

   localparam int OPW  = 8;
   localparam int PPW  = 16;
   localparam int NDIG = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Triplet {a[2i+1], a[2i], a[2i-1]} with an implicit zero below bit 0.
   function automatic logic [2:0] booth_digit(input logic [OPW-1:0] a, input logic [1:0] i);
      logic [OPW:0] ax;
      logic [2:0]   code;
      ax = {a, 1'b0};
      unique case (i)
         2'd0: code = ax[2:0];
         2'd1: code = ax[4:2];
         2'd2: code = ax[6:4];
         2'd3: code = ax[8:6];
      endcase
      return code;
   endfunction

   function automatic logic booth_is_zero(input logic [2:0] code);
      return (code == 3'b000) || (code == 3'b111);
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_digit_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_digit_sel : picks the next Booth digit to issue and its triplet      |
// | Option : BOOTH_SEQ_ZERO_SKIP_EN skips digits with a zero partial product    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module booth_digit_sel
   import booth_pkg::*;
(
   input  logic [OPW-1:0] a_val,
   input  logic [1:0]     cur_idx,
   input  logic           first,
   output logic [1:0]     nxt_idx,
   output logic [2:0]     nxt_opr,
   output logic           last
);

   always_comb begin
      nxt_idx = 2'd0;
      last    = 1'b1;
      if (first) begin
         last = 1'b0;
      end else begin
         // Descending scan so the lowest eligible digit above cur_idx wins.
         for (int j = NDIG - 1; j >= 1; j--) begin
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
            if ((j > int'(cur_idx)) && !booth_is_zero(booth_digit(a_val, 2'(j)))) begin
`else
            if (j > int'(cur_idx)) begin
`endif
               nxt_idx = 2'(j);
               last    = 1'b0;
            end
         end
      end
      nxt_opr = booth_digit(a_val, nxt_idx);
   end

endmodule
`default_nettype wire

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_seq_ctrl : sequences one signed 8x8 radix-4 Booth multiply through a |
// | shared partial-product generator. Option : BOOTH_SEQ_ZERO_SKIP_EN           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module booth_seq_ctrl
   import booth_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [PPW-1:0] product,
   output logic [2:0]     pp_opr,
   output logic [1:0]     pp_ext,
   output logic [OPW-1:0] pp_b,
   input  logic [PPW-1:0] pp_in
);

   state_t         state_q, state_d;
   logic [1:0]     idx_q, idx_d;
   logic [OPW-1:0] a_q, a_d;
   logic [OPW-1:0] b_q, b_d;
   logic [2:0]     opr_q, opr_d;
   logic [1:0]     ext_q, ext_d;
   logic           pend_q, pend_d;
   logic           pend_dly_q, pend_dly_d;
   logic [PPW-1:0] acc_q, acc_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [PPW-1:0] product_q, product_d;

   logic           sel_first;
   logic [OPW-1:0] sel_a;
   logic [1:0]     sel_idx;
   logic [2:0]     sel_opr;
   logic           sel_last;

   // Outside ISSUE the selector looks at the incoming operand so digit 0 is ready at accept.
   assign sel_first = (state_q != ISSUE);
   assign sel_a     = sel_first ? a : a_q;

   booth_digit_sel u_sel (
      .a_val   (sel_a),
      .cur_idx (idx_q),
      .first   (sel_first),
      .nxt_idx (sel_idx),
      .nxt_opr (sel_opr),
      .last    (sel_last)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      a_d        = a_q;
      b_d        = b_q;
      opr_d      = 3'b000;
      ext_d      = 2'b00;
      pend_d     = 1'b0;
      pend_dly_d = pend_q;
      acc_d      = pend_dly_q ? (acc_q + pp_in) : acc_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      product_d  = product_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = ISSUE;
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               idx_d   = sel_idx;
               opr_d   = sel_opr;
               ext_d   = sel_idx;
               pend_d  = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (sel_last) begin
               state_d = DRAIN;
            end else begin
               idx_d  = sel_idx;
               opr_d  = sel_opr;
               ext_d  = sel_idx;
               pend_d = 1'b1;
            end
         end
         DRAIN: begin
            // The last partial product lands in acc_d on this same edge.
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            product_d = acc_d;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         a_q        <= '0;
         b_q        <= '0;
         opr_q      <= 3'b000;
         ext_q      <= 2'b00;
         pend_q     <= 1'b0;
         pend_dly_q <= 1'b0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         product_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         opr_q      <= opr_d;
         ext_q      <= ext_d;
         pend_q     <= pend_d;
         pend_dly_q <= pend_dly_d;
         acc_q      <= acc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         product_q  <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign pp_opr  = opr_q;
   assign pp_ext  = ext_q;
   assign pp_b    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_booth_seq_ctrl : randomized bench with a behavioural multiply model     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_booth_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  ia = '0, ib = '0;
   logic        busy, done;
   logic [15:0] product;
   logic [2:0]  pp_opr;
   logic [1:0]  pp_ext;
   logic [7:0]  pp_b;
   logic [15:0] gen_q = 16'h5a5a;

   int total = 0;
   int bad   = 0;

   booth_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(ia), .b(ib),
      .busy(busy), .done(done), .product(product),
      .pp_opr(pp_opr), .pp_ext(pp_ext), .pp_b(pp_b), .pp_in(gen_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   typedef struct { logic [1:0] idx; logic [2:0] code; } dig_t;

   function automatic int bit_of(logic [7:0] v, int p);
      return (p < 0) ? 0 : int'(v[p]);
   endfunction

   function automatic logic [2:0] code_of(logic [7:0] v, int j);
      return {v[2*j+1], v[2*j], (j == 0) ? 1'b0 : v[2*j-1]};
   endfunction

   // Booth digit value: a[2j-1] + a[2j] - 2*a[2j+1]
   function automatic int dval(logic [7:0] v, int j);
      return bit_of(v, 2*j-1) + bit_of(v, 2*j) - 2*bit_of(v, 2*j+1);
   endfunction

   function automatic int num_issued(logic [7:0] v);
      int k = 1;
      for (int j = 1; j < 4; j++) begin
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
         if (dval(v, j) != 0) k++;
`else
         k++;
`endif
      end
      return k;
   endfunction

   function automatic logic [15:0] gen_pp(logic [2:0] c, logic [1:0] e, logic [7:0] bb);
      int d;
      int v;
      case (c)
         3'b001, 3'b010: d = 1;
         3'b011:         d = 2;
         3'b100:         d = -2;
         3'b101, 3'b110: d = -1;
         default:        d = 0;
      endcase
      v = int'($signed(bb)) * d * (1 << (2 * int'(e)));
      return v[15:0];
   endfunction

   function automatic logic [15:0] mul16(logic [7:0] x, logic [7:0] y);
      logic signed [15:0] p;
      p = $signed(x) * $signed(y);
      return p;
   endfunction

   bit          m_busy = 0, m_done = 0;
   int          m_left = 0;
   logic [15:0] m_prod = '0, m_next = '0;
   logic [7:0]  m_b = '0;
   dig_t        m_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_left = 0;
         m_prod = '0; m_next = '0; m_b = '0;
         m_q.delete();
      end else begin
         // Generator: genuine product when a digit is being issued, junk otherwise.
         if (m_q.size() > 0) gen_q <= gen_pp(pp_opr, pp_ext, pp_b);
         else                gen_q <= 16'($urandom);
         if (m_q.size() > 0) void'(m_q.pop_front());
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_prod = m_next;
            end
         end else if (start) begin
            m_busy = 1;
            m_left = num_issued(ia) + 1;
            m_next = mul16(ia, ib);
            m_b    = ib;
            for (int j = 0; j < 4; j++) begin
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
               if (j == 0 || dval(ia, j) != 0) m_q.push_back('{2'(j), code_of(ia, j)});
`else
               m_q.push_back('{2'(j), code_of(ia, j)});
`endif
            end
         end
      end
   end

   bit chk_en = 0;
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("product", product, m_prod);
         chk("pp_b", pp_b, m_b);
         chk("pp_opr", pp_opr, (m_q.size() > 0) ? m_q[0].code : 3'b000);
         chk("pp_ext", pp_ext, (m_q.size() > 0) ? m_q[0].idx : 2'b00);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_p,
                         input int exp_lat, input bit noise, input string nm);
      int n = 0;
      start = 1; ia = x; ib = y;
      do begin
         @(negedge clk);
         n++;
         start = 0;
         if (!done && noise) begin
            start = ($urandom_range(0, 2) == 0);
            ia = 8'($urandom); ib = 8'($urandom);
         end
      end while (!done && n < 20);
      if (!done) chk({nm, "_timeout"}, 0, 1);
      chk({nm, "_product"}, product, exp_p);
      chk({nm, "_latency"}, n - 1, exp_lat);
   endtask

   initial begin
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_product", product, 0);
      chk("rst_opr", pp_opr, 0);
      @(negedge clk); rst_n = 1; chk_en = 1;
      @(negedge clk);

`ifdef BOOTH_SEQ_ZERO_SKIP_EN
      do_mul(8'd3, 8'd7, 16'h0015, 3, 0, "a3b7");
`else
      do_mul(8'd3, 8'd7, 16'h0015, 5, 0, "a3b7");
`endif
      @(negedge clk);
      do_mul(8'h80, 8'h80, 16'h4000, num_issued(8'h80) + 1, 0, "m128m128");
      @(negedge clk);
      do_mul(8'h80, 8'd127, 16'hC080, num_issued(8'h80) + 1, 1, "m128p127_noise");
      @(negedge clk);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
      do_mul(8'd0, 8'd55, 16'h0000, 2, 0, "a0b55");
`else
      do_mul(8'd0, 8'd55, 16'h0000, 5, 0, "a0b55");
`endif
      do_mul(8'hFF, 8'hFF, 16'h0001, num_issued(8'hFF) + 1, 0, "b2b_m1m1");

      // Abort a multiply mid-flight.
      @(negedge clk);
      start = 1; ia = 8'd100; ib = 8'hCE;
      @(negedge clk); start = 0;
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_product", product, 0);
      chk("abort_opr", pp_opr, 0);
      chk("abort_ext", pp_ext, 0);
      chk("abort_pp_b", pp_b, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      do_mul(8'd5, 8'd5, 16'h0019, num_issued(8'd5) + 1, 0, "a5b5");

      for (int t = 0; t < 60; t++) begin
         logic [7:0] x, y;
         x = 8'($urandom); y = 8'($urandom);
         if (t % 8 == 0) x = 8'(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
         if (t % 8 == 1) x = 8'h7F;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_mul(x, y, mul16(x, y), num_issued(x) + 1, bit'($urandom_range(0, 1)), "rand");
      end
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
